// File: rtl/ctrl_scoreboard_if.sv
// Decode/writeback signal bundle for ctrl_scoreboard.
// master drives the decode and writeback side; slave is the scoreboard itself.
interface ctrl_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             i_valid;
    logic [15:0]      i_ir_dec;
    logic             i_stall;
    logic             i_registers_rd_en_r;
    logic [3:0]       i_addr_rd_r;
    logic             o_stall;
    logic             o_issue;
    logic [15:0]      o_pending;
    logic [CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_valid, i_ir_dec, i_stall, i_registers_rd_en_r, i_addr_rd_r,
        input  o_stall, o_issue, o_pending, o_stall_cnt
    );

    modport slave (
        input  i_valid, i_ir_dec, i_stall, i_registers_rd_en_r, i_addr_rd_r,
        output o_stall, o_issue, o_pending, o_stall_cnt
    );
endinterface

// File: rtl/ctrl_scoreboard.sv
// Decode-stage register scoreboard: one pending bit per register, RAW/WAW
// interlock against in-flight writebacks, and a saturating stall counter.
module ctrl_scoreboard #(
    parameter int SP_IDX = 13,
    parameter int PC_IDX = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_scoreboard_if.slave  sb
);

    localparam logic [3:0]       SP_R    = 4'(SP_IDX);
    localparam logic [3:0]       PC_R    = 4'(PC_IDX);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [15:0]      ir;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic [3:0]       dst;
    logic             src1_use;
    logic             src2_use;
    logic             dst_use;
    logic             src1_busy;
    logic             src2_busy;
    logic             dst_busy;
    logic             hazard;
    logic             stall;
    logic             issue;
    logic [15:0]      pending_q;
    logic [15:0]      pending_d;
    logic [CNT_W-1:0] stall_cnt_q;

    assign ir = sb.i_ir_dec;

    // Operand extraction for the subset of Thumb encodings that can interlock.
    always_comb begin
        src1     = 4'd0;
        src2     = 4'd0;
        dst      = 4'd0;
        src1_use = 1'b0;
        src2_use = 1'b0;
        dst_use  = 1'b0;
        casez (ir)
            16'b0001_110?_????_????: begin
                src1     = {1'b0, ir[5:3]};
                src1_use = 1'b1;
                dst      = {1'b0, ir[2:0]};
                dst_use  = 1'b1;
            end
            16'b1011_0000_1???_????: begin
                src1     = SP_R;
                src1_use = 1'b1;
                dst      = SP_R;
                dst_use  = 1'b1;
            end
            16'b0010_0???_????_????: begin
                dst      = {1'b0, ir[10:8]};
                dst_use  = 1'b1;
            end
            16'b0100_0110_????_????: begin
                src1     = ir[6:3];
                src1_use = 1'b1;
                dst      = {1'b0, ir[2:0]};
                dst_use  = 1'b1;
            end
            16'b0110_1???_????_????: begin
                src1     = {1'b0, ir[5:3]};
                src1_use = 1'b1;
                dst      = {1'b0, ir[2:0]};
                dst_use  = 1'b1;
            end
            16'b0100_1???_????_????: begin
                src1     = PC_R;
                src1_use = 1'b1;
                dst      = {1'b0, ir[10:8]};
                dst_use  = 1'b1;
            end
            16'b0110_0???_????_????: begin
                src1     = {1'b0, ir[5:3]};
                src1_use = 1'b1;
                src2     = {1'b0, ir[2:0]};
                src2_use = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // PC reads never wait: the PC is always architecturally ready.
    assign src1_busy = src1_use && (src1 != PC_R) && pending_q[src1];
    assign src2_busy = src2_use && (src2 != PC_R) && pending_q[src2];
    assign dst_busy  = dst_use  && (dst  != PC_R) && pending_q[dst];
    assign hazard    = src1_busy || src2_busy || dst_busy;

    assign stall = sb.i_valid && hazard && !rst;
    assign issue = sb.i_valid && !hazard && !sb.i_stall && !rst;

    // Writeback clear is applied first so a same-cycle issue to that register wins.
    always_comb begin
        pending_d = pending_q;
        if (sb.i_registers_rd_en_r) begin
            pending_d[sb.i_addr_rd_r] = 1'b0;
        end
        if (issue && dst_use) begin
            pending_d[dst] = 1'b1;
        end
        pending_d[PC_R] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 16'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign sb.o_stall     = stall;
    assign sb.o_issue     = issue;
    assign sb.o_pending   = pending_q;
    assign sb.o_stall_cnt = stall_cnt_q;

endmodule

// File: doc/ctrl_scoreboard.md
Name: ctrl_scoreboard

Overview:
- Decode-stage register scoreboard for the 16-bit Thumb pipeline.
- Consumes the writeback destination stream (register address plus write enable) that the memory stage produces.
- Tracks in-flight destination registers and stalls any decode-stage instruction that reads or writes a register with a pending write (RAW/WAW interlock).
- Sits beside the decode stage; its o_stall feeds the fetch/decode hold logic.

Parameters:
- SP_IDX, 13, register index used as implicit source/destination by SUB SP.
- PC_IDX, 15, register index of PC; never marked pending.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  i_ir_dec holds a real instruction this cycle.
- i_ir_dec  input  16  instruction in decode.
- i_stall  input  1  downstream pipeline stall; no issue this cycle.
- i_registers_rd_en_r  input  1  writeback enable from the memory stage.
- i_addr_rd_r  input  4  writeback destination register.
- o_stall  output  1  hazard stall request (combinational).
- o_issue  output  1  instruction accepted this cycle (combinational).
- o_pending  output  16  pending-write bit per register (registered).
- o_stall_cnt  output  CNT_W  saturating count of hazard-stall cycles (registered).

Behaviour:
- Reset: async, active-high. o_pending=0, o_stall_cnt=0. o_stall and o_issue are 0 while rst is high.
- Decode of i_ir_dec gives src1, src2 and dst, each with its own use flag:
  - [15:7]=0001110??, ADD imm3: src1=[5:3], dst={0,[2:0]}.
  - [15:7]=101100001, SUB SP: src1=SP_IDX, dst=SP_IDX.
  - [15:11]=00100, MOV imm: dst={0,[10:8]}, no sources.
  - [15:8]=01000110, MOV reg: src1=[6:3], dst={0,[2:0]}. Bit 7 is ignored for dst so it matches the writeback address.
  - [15:11]=01101, LDR imm: src1={0,[5:3]}, dst={0,[2:0]}.
  - [15:11]=01001, LDR literal: src1=PC_IDX, dst={0,[10:8]}.
  - [15:11]=01100, STR imm: src1={0,[5:3]}, src2={0,[2:0]}, no dst.
  - Anything else: no sources, no dst, never hazards.
- hazard = OR of o_pending[r] over every used src and dst; PC_IDX is always ready.
- o_stall = i_valid & hazard & ~rst.
- o_issue = i_valid & ~hazard & ~i_stall & ~rst.
- Sequential update, per register r at each rising edge:
  - set when o_issue & dst used & dst==r & r!=PC_IDX;
  - clear when i_registers_rd_en_r & i_addr_rd_r==r.
  - If set and clear hit the same r in one cycle, set wins (a new write is in flight).
- Writeback visibility: a cleared bit takes effect the cycle after the writeback pulse; there is no same-cycle bypass.
- Writeback to a non-pending register, or to PC_IDX: no effect.
- Because any pending dst stalls, at most one outstanding write per register exists; a single bit per register is sufficient.
- o_stall_cnt increments on every cycle with o_stall=1 and saturates at all-ones.
- i_stall with hazard: o_stall still reflects the hazard, and the counter counts it.
- i_stall without hazard: no issue, no counter change.
- Reset asserted mid-stream: every pending bit drops immediately; in-flight writebacks after reset release are harmless no-ops.

Test Plan:
- Reset, then issue MOV imm 0x2105 (dst r1) -> o_issue=1; next cycle o_pending=0x0002.
- With r1 pending, present ADD imm 0x1C4A (src r1, dst r2) -> o_stall=1, o_issue=0, o_stall_cnt increments each cycle. Pulse writeback r1 -> stall drops one cycle later; ADD issues; o_pending=0x0004.
- Issue SUB SP 0xB081 -> o_pending[13]=1. A following SUB SP stalls until writeback of addr 13.
- Issue LDR literal 0x4B02 (dst r3): PC is never pending, so it issues. Then STR 0x6019 (src r3, r1) stalls until writeback of r3.
- Same cycle: writeback r4 plus issue of MOV imm 0x2407 with r4 not pending -> o_pending[4]=1 (set wins). i_stall=1 with no hazard -> o_issue=0, no pending change.
- Assert rst mid-run with o_pending=0x2006 -> o_pending=0 and o_stall_cnt=0 without waiting for a clock edge. Drive the counter to 0xFFFF -> it holds at 0xFFFF.
